// File: rtl/bf16_f2i_pipe.sv
// -----------------------------------------------------------------------------
// bf16_f2i_pipe
//   Pipelined multi-lane BF16 -> integer converter with a valid/ready
//   handshake. Each lane converts independently using the rounding mode and
//   signedness captured with the transaction. Out-of-range results saturate.
//   The rounded value, tag and (optionally) the per-lane {NV, NX} flags travel
//   through STAGES register stages that all advance together.
//
//   Optional feature macro: BF16_F2I_STATUS_EN
//     defined   : flag logic and status pipeline are built
//     undefined : out_status is tied to zero (result values are unchanged)
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   in_valid     transaction offered
//   in_ready     block accepts the transaction this cycle (= advance enable)
//   in_data      BF16 operands, lane i at [16i+15:16i]
//   in_rnd       rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP
//   in_unsigned  1 = unsigned result, 0 = two's-complement signed
//   in_tag       opaque sideband returned with the result
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_data     integer results, lane i at [INT_WIDTH*i +: INT_WIDTH]
//   out_tag      tag of the result
//   out_status   per-lane {NV, NX}, lane i at [2i+1:2i]
// -----------------------------------------------------------------------------
module bf16_f2i_pipe #(
    parameter int LANES     = 1,
    parameter int INT_WIDTH = 16,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [16*LANES-1:0]        in_data,
    input  logic [1:0]                 in_rnd,
    input  logic                       in_unsigned,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INT_WIDTH*LANES-1:0] out_data,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic [2*LANES-1:0]         out_status
);

    localparam int DW = INT_WIDTH * LANES;
    localparam logic [INT_WIDTH-1:0] SMAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] SMIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
    localparam logic [INT_WIDTH-1:0] UMAX = {INT_WIDTH{1'b1}};

    // One lane conversion. Returns {NV, NX, result}.
    function automatic logic [INT_WIDTH+1:0] f2i_lane(
        input logic [15:0] x,
        input logic [1:0]  rnd,
        input logic        uns
    );
        logic                 sgn;
        logic [7:0]           ex;
        logic [6:0]           man;
        logic [38:0]          fx;
        logic [31:0]          mag;
        logic                 grd;
        logic                 stk;
        logic                 inx;
        logic                 inc;
        logic                 big;
        logic                 nan;
        logic                 ovf;
        logic                 nv;
        logic                 nx;
        logic [32:0]          mag_r;
        logic [33:0]          lim;
        logic [INT_WIDTH-1:0] res;

        sgn = x[15];
        ex  = x[14:7];
        man = x[6:0];
        fx  = 39'd0;
        mag = 32'd0;
        grd = 1'b0;
        stk = 1'b0;
        nan = (ex == 8'hFF) && (man != 7'd0);
        // |value| >= 2^32 (including inf/NaN) exceeds every representable bound
        big = (ex >= 8'd159);

        if (big) begin
            mag = 32'd0;
        end else if (ex >= 8'd127) begin
            // 1.m with 7 fraction bits, shifted by the unbiased exponent (0..31)
            fx  = {31'd0, 1'b1, man} << (ex - 8'd127);
            mag = fx[38:7];
            grd = fx[6];
            stk = |fx[5:0];
        end else if (ex == 8'd126) begin
            // value in [0.5, 1): leading one is the guard bit
            grd = 1'b1;
            stk = |man;
        end else begin
            // below 0.5 (including denormals): only sticky, unless exactly zero
            grd = 1'b0;
            stk = (ex != 8'd0) || (man != 7'd0);
        end

        inx = grd | stk;
        // rounding acts on the signed value, so directed modes depend on sign
        case (rnd)
            2'd0:    inc = grd & (stk | mag[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = sgn & inx;
            2'd3:    inc = ~sgn & inx;
            default: inc = 1'b0;
        endcase
        mag_r = {1'b0, mag} + {32'd0, inc};

        // largest magnitude representable for this sign/signedness
        if (uns) begin
            lim = sgn ? 34'd0 : ((34'd1 << INT_WIDTH) - 34'd1);
        end else begin
            lim = sgn ? (34'd1 << (INT_WIDTH-1)) : ((34'd1 << (INT_WIDTH-1)) - 34'd1);
        end
        ovf = big || ({1'b0, mag_r} > lim);

        if (nan) begin
            res = uns ? UMAX : SMAX;
            nv  = 1'b1;
        end else if (ovf) begin
            if (uns) begin
                res = sgn ? {INT_WIDTH{1'b0}} : UMAX;
            end else begin
                res = sgn ? SMIN : SMAX;
            end
            nv = 1'b1;
        end else begin
            res = sgn ? ({INT_WIDTH{1'b0}} - mag_r[INT_WIDTH-1:0]) : mag_r[INT_WIDTH-1:0];
            nv  = 1'b0;
        end
        nx = ~nv & inx;
        return {nv, nx, res};
    endfunction

    logic [STAGES-1:0]    vld_r;
    logic [DW-1:0]        data_r [STAGES];
    logic [TAG_WIDTH-1:0] tag_r  [STAGES];
    logic [DW-1:0]        conv_data_s;
    logic                 adv_s;

    // Whole pipeline advances together; it only holds when the output is blocked
    assign adv_s     = out_ready || !vld_r[STAGES-1];
    assign in_ready  = adv_s;
    assign out_valid = vld_r[STAGES-1];
    assign out_data  = data_r[STAGES-1];
    assign out_tag   = tag_r[STAGES-1];

    // Per-lane conversion of the offered operands
    always_comb begin
        conv_data_s = '0;
        for (int i = 0; i < LANES; i++) begin
            conv_data_s[i*INT_WIDTH +: INT_WIDTH] =
                INT_WIDTH'(f2i_lane(in_data[16*i +: 16], in_rnd, in_unsigned));
        end
    end

    // Result/tag/valid shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_r[k] <= '0;
                tag_r[k]  <= '0;
            end
        end else if (adv_s) begin
            vld_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= conv_data_s;
                tag_r[0]  <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                vld_r[k]  <= vld_r[k-1];
                data_r[k] <= data_r[k-1];
                tag_r[k]  <= tag_r[k-1];
            end
        end
    end

`ifdef BF16_F2I_STATUS_EN
    logic [2*LANES-1:0] st_r [STAGES];
    logic [2*LANES-1:0] conv_st_s;

    // Per-lane {NV, NX} flags of the offered operands
    always_comb begin
        conv_st_s = '0;
        for (int i = 0; i < LANES; i++) begin
            conv_st_s[2*i +: 2] =
                2'(f2i_lane(in_data[16*i +: 16], in_rnd, in_unsigned) >> INT_WIDTH);
        end
    end

    // Status shift register, advancing in lockstep with the results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_r[k] <= '0;
            end
        end else if (adv_s) begin
            if (in_valid) begin
                st_r[0] <= conv_st_s;
            end
            for (int k = 1; k < STAGES; k++) begin
                st_r[k] <= st_r[k-1];
            end
        end
    end

    assign out_status = st_r[STAGES-1];
`else
    assign out_status = '0;
`endif

endmodule

// File: tb/tb_bf16_f2i_pipe.sv
// -----------------------------------------------------------------------------
// tb_bf16_f2i_pipe
//   Self-checking bench for bf16_f2i_pipe (LANES=4, INT_WIDTH=16, STAGES=2).
//   Expected results come from a real-number model of the conversion rules;
//   a single monitor compares every valid output against a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_bf16_f2i_pipe;

    localparam int L  = 4;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [16*L-1:0] in_data;
    logic [1:0]      in_rnd;
    logic            in_unsigned;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W*L-1:0]  out_data;
    logic [TW-1:0]   out_tag;
    logic [2*L-1:0]  out_status;

    bf16_f2i_pipe #(.LANES(L), .INT_WIDTH(W), .STAGES(S), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_rnd(in_rnd), .in_unsigned(in_unsigned), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_status(out_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W*L-1:0] data;
        logic [2*L-1:0] st;
        logic [TW-1:0]  tag;
        int             acc;
        int             stalls;
        bit             seen;
        bit             has_lit;
        logic [15:0]    lit_d;
        logic [1:0]     lit_st;
    } exp_t;

    typedef struct packed {
        logic [15:0] x;
        logic [1:0]  rnd;
        logic        uns;
        logic [15:0] d;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs [22] = '{
        '{16'h4060, 2'd0, 1'b0, 16'h0004, 2'b01},
        '{16'h4060, 2'd1, 1'b0, 16'h0003, 2'b01},
        '{16'hC020, 2'd0, 1'b0, 16'hFFFE, 2'b01},
        '{16'hC020, 2'd2, 1'b0, 16'hFFFD, 2'b01},
        '{16'hC020, 2'd3, 1'b0, 16'hFFFE, 2'b01},
        '{16'h4F80, 2'd0, 1'b0, 16'h7FFF, 2'b10},
        '{16'h7FC0, 2'd0, 1'b0, 16'h7FFF, 2'b10},
        '{16'hFF80, 2'd0, 1'b0, 16'h8000, 2'b10},
        '{16'hBF80, 2'd0, 1'b1, 16'h0000, 2'b10},
        '{16'hBE80, 2'd0, 1'b1, 16'h0000, 2'b01},
        '{16'h477F, 2'd0, 1'b1, 16'hFF00, 2'b00},
        '{16'h4700, 2'd0, 1'b0, 16'h7FFF, 2'b10},
        '{16'hC700, 2'd0, 1'b0, 16'h8000, 2'b00},
        '{16'h4780, 2'd0, 1'b1, 16'hFFFF, 2'b10},
        '{16'h0001, 2'd3, 1'b0, 16'h0001, 2'b01},
        '{16'h8001, 2'd2, 1'b0, 16'hFFFF, 2'b01},
        '{16'h3F00, 2'd0, 1'b0, 16'h0000, 2'b01},
        '{16'h3FC0, 2'd0, 1'b0, 16'h0002, 2'b01},
        '{16'h8000, 2'd0, 1'b1, 16'h0000, 2'b00},
        '{16'h7F80, 2'd0, 1'b1, 16'hFFFF, 2'b10},
        '{16'hFF80, 2'd0, 1'b1, 16'h0000, 2'b10},
        '{16'hFFC1, 2'd0, 1'b1, 16'hFFFF, 2'b10}
    };

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    bit          prev_stall = 1'b0;
    int          out_mode = 0;
    int          pc = 0;
    bit          cur_lv = 1'b0;
    logic [15:0] cur_ld = 16'd0;
    logic [1:0]  cur_ls = 2'd0;
    exp_t        exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decode to a real, round with floor/ceil, clamp to the range.
    function automatic void ref_lane(input logic [15:0] x, input logic [1:0] rnd, input bit uns,
                                     output logic [W-1:0] res, output logic [1:0] fl);
        int  e;
        int  m;
        real v, f, d, r, lo, hi;
        bit  nv, nx;
        e  = int'(x[14:7]);
        m  = int'(x[6:0]);
        lo = uns ? 0.0 : -(2.0 ** real'(W-1));
        hi = uns ? (2.0 ** real'(W)) - 1.0 : (2.0 ** real'(W-1)) - 1.0;
        nv = 1'b0;
        nx = 1'b0;
        if (e == 255) begin
            nv = 1'b1;
            r  = (m != 0 || !x[15]) ? hi : lo;
        end else begin
            if (e == 0) v = real'(m) * (2.0 ** -133.0);
            else        v = (1.0 + real'(m) / 128.0) * (2.0 ** real'(e - 127));
            if (x[15]) v = -v;
            f = $floor(v);
            d = v - f;
            case (rnd)
                2'd0: begin
                    if (d > 0.5)                          r = f + 1.0;
                    else if (d < 0.5)                     r = f;
                    else if ($floor(f / 2.0) * 2.0 == f)  r = f;
                    else                                  r = f + 1.0;
                end
                2'd1:    r = (v < 0.0) ? $ceil(v) : f;
                2'd2:    r = f;
                default: r = $ceil(v);
            endcase
            nx = (r != v);
            if (r > hi) begin
                r = hi; nv = 1'b1;
            end else if (r < lo) begin
                r = lo; nv = 1'b1;
            end
            if (nv) nx = 1'b0;
        end
        res = W'(longint'(r));
        fl  = {nv, nx};
    endfunction

    function automatic logic [15:0] rand_bf16();
        logic [15:0] x;
        int k;
        x = 16'($urandom);
        k = $urandom_range(0, 3);
        case (k)
            1:       x[14:7] = 8'($urandom_range(118, 160));
            2:       x[14:7] = 8'($urandom_range(124, 130));
            3:       x[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            default: x = x;
        endcase
        return x;
    endfunction

    function automatic logic [16*L-1:0] rand_lanes();
        logic [16*L-1:0] d;
        for (int i = 0; i < L; i++) d[16*i +: 16] = rand_bf16();
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready driver: 0 always ready, 1 pattern 1,0,0,..., 2 random
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (out_mode)
                1:       out_ready = (pc % 3 == 0);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            pc++;
        end
    end

    // Monitor / scoreboard: samples 2 time units after the falling edge
    always @(negedge clk) begin
        exp_t            h;
        exp_t            e;
        logic [W-1:0]    r;
        logic [1:0]      fl;
        #2;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_tag", out_tag, 0);
            chk("rst_out_status", out_status, 0);
            chk("rst_in_ready", in_ready, 1);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold_valid", out_valid, 1);
            chk("in_ready_rule", in_ready, out_ready || !out_valid);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", out_valid, 0);
                end else begin
                    h = exp_q[0];
                    if (!h.seen && h.stalls == stall_cnt) chk("latency", cyc - h.acc, S);
                    exp_q[0].seen = 1'b1;
                    chk("out_data", out_data, h.data);
                    chk("out_status", out_status, h.st);
                    chk("out_tag", out_tag, h.tag);
                    if (h.has_lit) begin
                        chk("lit_data_lane0", out_data[W-1:0], h.lit_d);
`ifdef BF16_F2I_STATUS_EN
                        chk("lit_status_lane0", out_status[1:0], h.lit_st);
`endif
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cnt++;
            if (in_valid && in_ready) begin
                for (int i = 0; i < L; i++) begin
                    ref_lane(in_data[16*i +: 16], in_rnd, in_unsigned, r, fl);
                    e.data[W*i +: W] = r;
`ifdef BF16_F2I_STATUS_EN
                    e.st[2*i +: 2] = fl;
`else
                    e.st[2*i +: 2] = 2'b00;
`endif
                end
                e.tag     = in_tag;
                e.acc     = cyc;
                e.stalls  = stall_cnt;
                e.seen    = 1'b0;
                e.has_lit = cur_lv;
                e.lit_d   = cur_ld;
                e.lit_st  = cur_ls;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [16*L-1:0] d, input logic [1:0] rnd, input bit uns,
                        input logic [TW-1:0] tag, input bit lv, input logic [15:0] ld,
                        input logic [1:0] ls);
        int n;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        in_rnd      = rnd;
        in_unsigned = uns;
        in_tag      = tag;
        cur_lv      = lv;
        cur_ld      = ld;
        cur_ls      = ls;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            cur_lv   = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [1:0]   fl;
        int           n;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_rnd      = 2'd0;
        in_unsigned = 1'b0;
        in_tag      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Pin the reference model on hand-computed values
        ref_lane(16'h4060, 2'd1, 1'b0, r, fl);
        chk("model_3p5_rtz", {fl, r}, {2'b01, 16'h0003});
        ref_lane(16'hC020, 2'd2, 1'b0, r, fl);
        chk("model_m2p5_rdn", {fl, r}, {2'b01, 16'hFFFD});
        ref_lane(16'h477F, 2'd0, 1'b1, r, fl);
        chk("model_65280_uns", {fl, r}, {2'b00, 16'hFF00});
        ref_lane(16'hFF80, 2'd0, 1'b0, r, fl);
        chk("model_ninf", {fl, r}, {2'b10, 16'h8000});

        // Directed vectors on lane 0, random operands on the other lanes
        out_mode = 0;
        for (int i = 0; i < 22; i++) begin
            send({rand_lanes() >> 16, vecs[i].x} , vecs[i].rnd, vecs[i].uns, TW'(i),
                 1'b1, vecs[i].d, vecs[i].st);
        end
        idle(5);

        // Back-to-back stream under a 1,0,0 out_ready pattern
        pc       = 0;
        out_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send(rand_lanes(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), TW'(i),
                 1'b0, 16'd0, 2'd0);
        end
        idle(12);

        // Random traffic with random gaps and backpressure
        out_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(rand_lanes(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 TW'($urandom), 1'b0, 16'd0, 2'd0);
        end
        idle(1);
        out_mode = 0;
        idle(10);

        // Reset with two transactions in flight, then a fresh one
        send(rand_lanes(), 2'd0, 1'b0, 4'hA, 1'b0, 16'd0, 2'd0);
        send(rand_lanes(), 2'd0, 1'b0, 4'hB, 1'b0, 16'd0, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        cur_lv   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        send({rand_lanes() >> 16, 16'h3FC0}, 2'd0, 1'b0, 4'h5, 1'b1, 16'h0002, 2'b01);
        idle(5);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
